// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store front-end.
// Contents:
//   size_e   - access size encoding (byte / half / word / illegal)
//   state_e  - controller state encoding (IDLE / RD / RESP)
//   be_gen   - byte-enable pattern for a size and byte offset
//   wdata_gen- lane replication of right-justified store data
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    RESP = 2'b10
  } state_e;

  // A half access only looks at addr[1]; addr[0] never shifts the enables,
  // so an unchecked misaligned half lands on its containing aligned half.
  function automatic logic [3:0] be_gen(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_B:    be = 4'b0001 << addr_lo;
      SZ_H:    be = 4'b0011 << {addr_lo[1], 1'b0};
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // The RAM picks lanes with byte enables, so the data is simply copied
  // into every lane it could land in.
  function automatic logic [31:0] wdata_gen(input logic [1:0]  size,
                                            input logic [31:0] wdata);
    logic [31:0] wd;
    wd = wdata;
    case (size)
      SZ_B:    wd = {4{wdata[7:0]}};
      SZ_H:    wd = {2{wdata[15:0]}};
      default: wd = wdata;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_if.sv
// CPU-side request/response channel of the load/store front-end.
// Request : req_valid/req_ready handshake carrying we, size, unsigned,
//           byte address and right-justified store data.
// Response: resp_valid/resp_ready handshake carrying extended load data
//           and an access-fault flag.
// Modports: master = CPU side, slave = dmem_lsu_ctrl.
interface dmem_lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lsu_ctrl_load_align.sv
// Load-data formatter: selects the addressed byte/half/word lane of a RAM
// read word and sign- or zero-extends it to 32 bits.
// Ports:
//   rd_data     in  32  raw RAM read word
//   addr_lo     in   2  byte offset of the access
//   size        in   2  access size (size_e encoding)
//   is_unsigned in   1  zero-extend instead of sign-extend
//   result      out 32  formatted load data (0 for an illegal size)
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rd_data,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path through the case leaves it unassigned (no latch).
  always_comb begin
    byte_lane = rd_data[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];
    result    = '0;
    case (size)
      SZ_B:    result = is_unsigned ? {24'b0, byte_lane}
                                    : {{24{byte_lane[7]}}, byte_lane};
      SZ_H:    result = is_unsigned ? {16'b0, half_lane}
                                    : {{16{half_lane[15]}}, half_lane};
      SZ_W:    result = rd_data;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store front-end for a 32-bit single-port data RAM (1-cycle read
// latency, byte enables). Accepts one CPU request at a time, drives the RAM
// address/enables/data, and returns a formatted load result or a store
// acknowledge on the response channel.
// Ports:
//   clk            in   1           clock
//   tb_rst         in   1           asynchronous active-high reset
//   bus            slave modport    CPU request/response channel
//   ram_addr       out  ADDR_WIDTH  RAM word address
//   ram_wr_data    out  DATA_WIDTH  lane-replicated write data
//   ram_wr_en      out  1           write strobe (accept cycle of a store)
//   ram_wr_byte_en out  BE_WIDTH    byte enables, 0 when not writing
//   ram_rd_data    in   DATA_WIDTH  RAM read data, one cycle after address
// Build option: define DMEM_MISALIGN_CHECK_EN to fault misaligned half/word
// accesses; otherwise the offending low address bits are ignored.
module dmem_lsu_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  dmem_lsu_ctrl_if.slave        bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("dmem_lsu_ctrl: DATA_WIDTH must be 32");
  end
  if (BE_WIDTH != DATA_WIDTH / 8) begin : g_bad_be_width
    $error("dmem_lsu_ctrl: BE_WIDTH must equal DATA_WIDTH/8");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
    $error("dmem_lsu_ctrl: ADDR_WIDTH must be in 1..29");
  end

  state_e                state_q, state_d;
  logic                  accept;
  logic                  range_err, size_err, misalign_err, req_err;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            lo_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic [31:0]           load_result;

  // Fault decode on the live request; only meaningful in the accept cycle.
  always_comb begin
    range_err = |bus.req_addr[31:ADDR_WIDTH+2];
    size_err  = (bus.req_size == SZ_ILL);
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign_err = ((bus.req_size == SZ_H) && bus.req_addr[0]) ||
                   ((bus.req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign_err = 1'b0;
`endif
    req_err = range_err | size_err | misalign_err;
  end

  // Next state and handshake outputs. req_ready is gated by tb_rst so no
  // request can be accepted while reset is held.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    ram_wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = ~tb_rst;
        accept        = bus.req_valid & ~tb_rst;
        ram_wr_en     = accept & bus.req_we & ~req_err;
        if (accept) state_d = (bus.req_we || req_err) ? RESP : RD;
      end
      RD:   state_d = RESP;
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the address flows straight through so the RAM samples it at the
  // accept edge; afterwards it is held from the register.
  always_comb begin
    ram_addr       = (state_q == IDLE) ? bus.req_addr[ADDR_WIDTH+1:2] : addr_q;
    ram_wr_data    = wdata_gen(bus.req_size, bus.req_wdata);
    ram_wr_byte_en = ram_wr_en ? be_gen(bus.req_size, bus.req_addr[1:0])
                               : '0;
  end

  dmem_load_align u_load_align (
    .rd_data     (ram_rd_data),
    .addr_lo     (lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (load_result)
  );

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      addr_q  <= '0;
      lo_q    <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.req_addr[ADDR_WIDTH+1:2];
      lo_q    <= bus.req_addr[1:0];
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      rdata_q <= '0;
      err_q   <= req_err;
    end else if (state_q == RD) begin
      rdata_q <= load_result;
      err_q   <= 1'b0;
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: a behavioural 1-cycle-latency RAM,
// a scoreboard queue of expected responses, and one task per scenario.
module tb_dmem_lsu_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        tb_rst;
  logic [13:0] ram_addr;
  logic [31:0] ram_wr_data;
  logic        ram_wr_en;
  logic [3:0]  ram_wr_byte_en;
  logic [31:0] ram_rd_data;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  dmem_lsu_ctrl_if bus ();

  dmem_lsu_ctrl #(
    .ADDR_WIDTH (14),
    .DATA_WIDTH (32),
    .BE_WIDTH   (4)
  ) dut (
    .clk            (clk),
    .tb_rst         (tb_rst),
    .bus            (bus.slave),
    .ram_addr       (ram_addr),
    .ram_wr_data    (ram_wr_data),
    .ram_wr_en      (ram_wr_en),
    .ram_wr_byte_en (ram_wr_byte_en),
    .ram_rd_data    (ram_rd_data)
  );

  // NOTE: the RAM array is not reset; only words written first are read.
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    logic [31:0] w;
    w = mem[ram_addr];
    if (ram_wr_en === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (ram_wr_byte_en[b]) w[8*b +: 8] = ram_wr_data[8*b +: 8];
      mem[ram_addr] <= w;
      wr_count      <= wr_count + 1;
    end
    ram_rd_data <= mem[ram_addr];
  end

  // Drive one request, check the accept-cycle RAM strobes, push expectation.
  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd);
    exp_t e;
    int   waitc;
    logic exp_wr;
    @(negedge clk);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    #1;
    waitc = 0;
    while (bus.req_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk); #1; waitc++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: req_ready got %b want 1 (timeout)", name, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    exp_wr = we & ~exp_err;
    checks++;
    if (ram_wr_en !== exp_wr) begin
      errors++;
      $display("FAIL %s wr_en: got %b want %b", name, ram_wr_en, exp_wr);
    end
    checks++;
    if (ram_wr_byte_en !== (exp_wr ? exp_be : 4'b0000)) begin
      errors++;
      $display("FAIL %s byte_en: got %b want %b", name, ram_wr_byte_en,
               exp_wr ? exp_be : 4'b0000);
    end
    if (exp_wr) begin
      checks++;
      if (ram_wr_data !== exp_wd) begin
        errors++;
        $display("FAIL %s wr_data: got %h want %h", name, ram_wr_data, exp_wd);
      end
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = (we || exp_err) ? 1 : 2;
    e.name  = name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Wait (bounded) for resp_valid, compare against the scoreboard head,
  // then let the handshake complete (resp_ready assumed high).
  task automatic collect();
    exp_t e;
    int   cyc;
    cyc = 1;
    while (bus.resp_valid !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: response with empty queue, valid=%b", bus.resp_valid);
      return;
    end
    e = sb_q.pop_front();
    if (bus.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s resp_valid: got %b want 1 (timeout)", e.name, bus.resp_valid);
      return;
    end
    checks++;
    if (cyc != e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", e.name, cyc, e.lat);
    end
    checks++;
    if (bus.resp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h want %h", e.name, bus.resp_rdata, e.rdata);
    end
    checks++;
    if (bus.resp_err !== e.err) begin
      errors++;
      $display("FAIL %s err: got %b want %b", e.name, bus.resp_err, e.err);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s resp_valid after handshake: got %b want 0", e.name, bus.resp_valid);
    end
  endtask

  task automatic access(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
    issue(name, we, size, uns, addr, wdata, exp_rdata, exp_err, exp_be, exp_wd);
    collect();
  endtask

  task automatic test_reset();
    tb_rst           = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b1;
    #12;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, ram_wr_en} !== 4'b0000 ||
        bus.resp_rdata !== 32'h0 || ram_wr_byte_en !== 4'b0000) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b err=%b wr=%b be=%b rdata=%h want all 0",
               bus.req_ready, bus.resp_valid, bus.resp_err, ram_wr_en,
               ram_wr_byte_en, bus.resp_rdata);
    end
    @(negedge clk);
    tb_rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: req_ready got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_word();
    access("sw_100", 1'b1, SZ_W, 1'b0, 32'h100, 32'h1234_5678, 32'h0, 1'b0,
           4'b1111, 32'h1234_5678);
    access("lw_100", 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 1'b0,
           4'b0000, 32'h0);
  endtask

  task automatic test_byte();
    access("sb_103", 1'b1, SZ_B, 1'b0, 32'h103, 32'h0000_00AB, 32'h0, 1'b0,
           4'b1000, 32'hABAB_ABAB);
    access("lb_103", 1'b0, SZ_B, 1'b0, 32'h103, 32'h0, 32'hFFFF_FFAB, 1'b0, 4'b0, 32'h0);
    access("lbu_103", 1'b0, SZ_B, 1'b1, 32'h103, 32'h0, 32'h0000_00AB, 1'b0, 4'b0, 32'h0);
    access("lb_101", 1'b0, SZ_B, 1'b0, 32'h101, 32'h0, 32'h0000_0056, 1'b0, 4'b0, 32'h0);
    access("lw_merge", 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'hAB34_5678, 1'b0, 4'b0, 32'h0);
  endtask

  task automatic test_half();
    access("sh_102", 1'b1, SZ_H, 1'b0, 32'h102, 32'h0000_8001, 32'h0, 1'b0,
           4'b1100, 32'h8001_8001);
    access("lh_102", 1'b0, SZ_H, 1'b0, 32'h102, 32'h0, 32'hFFFF_8001, 1'b0, 4'b0, 32'h0);
    access("lhu_102", 1'b0, SZ_H, 1'b1, 32'h102, 32'h0, 32'h0000_8001, 1'b0, 4'b0, 32'h0);
    access("lh_100", 1'b0, SZ_H, 1'b0, 32'h100, 32'h0, 32'h0000_5678, 1'b0, 4'b0, 32'h0);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   cyc;
    int   wr0;
    bus.resp_ready = 1'b0;
    issue("bp_lw", 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h8001_5678, 1'b0, 4'b0, 32'h0);
    cyc = 1;
    while (bus.resp_valid !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    e = sb_q.pop_front();
    checks++;
    if (bus.resp_valid !== 1'b1 || cyc != 2) begin
      errors++;
      $display("FAIL bp_lw first_valid: valid=%b cycles=%0d want 1 / 2", bus.resp_valid, cyc);
    end
    // A competing store is presented while the response is stalled.
    @(negedge clk);
    wr0              = wr_count;
    bus.req_we       = 1'b1;
    bus.req_size     = SZ_W;
    bus.req_addr     = 32'h100;
    bus.req_wdata    = 32'hDEAD_BEEF;
    bus.req_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rdata || bus.resp_err !== 1'b0 ||
          bus.req_ready !== 1'b0 || ram_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b rdata=%h err=%b rdy=%b wr=%b want 1 %h 0 0 0",
                 i, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready,
                 ram_wr_en, e.rdata);
      end
    end
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || wr_count != wr0) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b writes=%0d want 0 1 %0d",
               bus.resp_valid, bus.req_ready, wr_count, wr0);
    end
  endtask

  task automatic test_errors();
    int wr0;
    wr0 = wr_count;
    access("sw_range", 1'b1, SZ_W, 1'b0, 32'h0001_0000, 32'hCAFE_F00D, 32'h0, 1'b1,
           4'b0, 32'h0);
    access("sw_size11", 1'b1, SZ_ILL, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b1,
           4'b0, 32'h0);
    access("lw_size11", 1'b0, SZ_ILL, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
    access("lb_range", 1'b0, SZ_B, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
    checks++;
    if (wr_count != wr0) begin
      errors++;
      $display("FAIL err_no_write: writes got %0d want %0d", wr_count, wr0);
    end
    access("lw_after_err", 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h8001_5678, 1'b0,
           4'b0, 32'h0);
    access("lw_top", 1'b0, SZ_W, 1'b0, 32'h0000_FFFC, 32'h0, 32'h0, 1'b0, 4'b0, 32'h0)
      ;
  endtask

  task automatic test_misalign();
`ifdef DMEM_MISALIGN_CHECK_EN
    access("lw_102", 1'b0, SZ_W, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
    access("lh_101", 1'b0, SZ_H, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
`else
    access("lw_102", 1'b0, SZ_W, 1'b0, 32'h102, 32'h0, 32'h8001_5678, 1'b0, 4'b0, 32'h0);
    access("lh_101", 1'b0, SZ_H, 1'b0, 32'h101, 32'h0, 32'h0000_5678, 1'b0, 4'b0, 32'h0);
`endif
  endtask

  task automatic test_reset_mid();
    int cyc;
    // Reset while waiting for read data.
    issue("rst_rd", 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h8001_5678, 1'b0, 4'b0, 32'h0);
    #1 tb_rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd_now: rdy=%b vld=%b want 0 0", bus.req_ready, bus.resp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd_held: rdy=%b vld=%b want 0 0", bus.req_ready, bus.resp_valid);
    end
    @(negedge clk);
    tb_rst = 1'b0;
    sb_q.delete();
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd_release: rdy=%b vld=%b want 1 0", bus.req_ready, bus.resp_valid);
    end
    access("lw_after_rst", 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h8001_5678, 1'b0,
           4'b0, 32'h0);
    // Reset while a response is held by backpressure.
    bus.resp_ready = 1'b0;
    issue("rst_resp", 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h8001_5678, 1'b0, 4'b0, 32'h0);
    cyc = 1;
    while (bus.resp_valid !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    sb_q.delete();
    #2 tb_rst = 1'b1;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_resp_drop: vld=%b err=%b rdata=%h want 0 0 0",
               bus.resp_valid, bus.resp_err, bus.resp_rdata);
    end
    @(negedge clk);
    tb_rst         = 1'b0;
    bus.resp_ready = 1'b1;
    access("sb_after_rst", 1'b1, SZ_B, 1'b0, 32'h200, 32'h0000_0011, 32'h0, 1'b0,
           4'b0001, 32'h1111_1111);
    access("lbu_after_rst", 1'b0, SZ_B, 1'b1, 32'h200, 32'h0, 32'h0000_0011, 1'b0,
           4'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    access("sw_fffc", 1'b1, SZ_W, 1'b0, 32'h0000_FFFC, 32'h0, 32'h0, 1'b0,
           4'b1111, 32'h0);
    test_word();
    test_byte();
    test_half();
    test_backpressure();
    test_errors();
    test_misalign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
- Load/store front-end sitting directly upstream of the 32-bit single-port data RAM (16K words, 4 byte enables, 1-cycle read latency, no output register).
- Accepts CPU byte-addressed requests over a valid/ready handshake and generates RAM word address, byte enables and lane-replicated write data.
- Returns sign/zero-extended load data, or a store acknowledge, over a valid/ready response channel.
- Supports one outstanding access.

Parameters:
ADDR_WIDTH, 14, RAM word-address width; byte range is 0 .. 4*2^ADDR_WIDTH-1.
DATA_WIDTH, 32, RAM data width; fixed at 32, elaborate-time error otherwise.
BE_WIDTH, 4, byte enables; must equal DATA_WIDTH/8.

Ports:
clk  in  1  clock
tb_rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (error)
req_unsigned  in  1  load zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  response valid
resp_ready  in  1  response consumed when valid&ready
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  access fault
ram_addr  out  ADDR_WIDTH  RAM word address
ram_wr_data  out  32  RAM write data
ram_wr_en  out  1  RAM write strobe
ram_wr_byte_en  out  BE_WIDTH  RAM byte enables
ram_rd_data  in  32  RAM read data, valid one cycle after address sampled

Behaviour:
- Clock clk; reset tb_rst, asynchronous, active-high.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, ram_wr_en 0, ram_wr_byte_en 0. req_ready is forced 0 while tb_rst is high.
- States:
  - IDLE: req_ready=1. ram_addr is driven combinationally from req_addr[ADDR_WIDTH+1:2].
  - RD: waits for RAM read data. ram_addr is held at the registered request address.
  - RESP: resp_valid=1. Held stable until resp_ready.
- Transitions:
  - IDLE + accepted load, no error -> RD.
  - IDLE + accepted store, or any error -> RESP.
  - RD -> RESP unconditionally; ram_rd_data is formatted and registered.
  - RESP & resp_ready -> IDLE.
- Latency:
  - Store accepted in cycle N: RAM write at edge N; resp_valid in cycle N+1.
  - Load accepted in cycle N: resp_valid in cycle N+2.
  - Throughput: one access per 3 cycles (load) or 2 cycles (store) with resp_ready=1.
- Writes:
  - ram_wr_en = req_valid & req_ready & req_we & ~err, combinational in the accept cycle only. Never asserted in RD or RESP.
  - Byte: byte_en = 1<<addr[1:0]; wr_data = wdata[7:0] replicated x4.
  - Half: byte_en = 4'b0011 << (2*addr[1]); wr_data = wdata[15:0] replicated x2.
  - Word: byte_en = 4'b1111.
  - ram_wr_byte_en is 0 whenever ram_wr_en is 0.
- Load extraction:
  - Lane is taken from the registered addr[1:0].
  - Byte/half are sign-extended unless req_unsigned is set.
- Errors (resp_err=1, no RAM write, resp_rdata=0):
  - req_addr >= 4*2^ADDR_WIDTH.
  - req_size==11.
  - Misalignment, per the optional feature below.
- Backpressure: in RESP with resp_ready=0, resp_valid, resp_rdata and resp_err stay stable and no new request is accepted.
- Reset mid-operation: asynchronous return to IDLE; resp_valid drops immediately; any held response is discarded. A RAM write already sampled at an edge is not undone.

Optional Feature:
- Macro DMEM_MISALIGN_CHECK_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, sets resp_err=1 and performs no RAM access.
- Undefined: offending low bits are ignored (half uses addr[1], word uses addr[1:0]=00). The access proceeds; resp_err covers only range and size faults.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
  - state encoding IDLE/RD/RESP;
  - byte-enable generation function.
- Sub-module dmem_load_align: combinational lane select plus sign/zero extension, inputs rd_data/addr[1:0]/size/unsigned, output 32-bit result.

Test Plan:
- SW 0x12345678 @0x100, then LW @0x100 -> ram_wr_byte_en=1111 on the accept cycle; store resp at N+1; load resp at N+2 with rdata=0x12345678, err=0.
- SB 0xAB @0x103 -> byte_en=1000, wr_data=0xABABABAB. Then LB @0x103 -> 0xFFFFFFAB; LBU @0x103 -> 0x000000AB; LW @0x100 -> 0xAB345678.
- SH 0x8001 @0x102 -> byte_en=1100. Then LH @0x102 -> 0xFFFF8001; LHU @0x102 -> 0x00008001.
- LW with resp_ready held 0 for 5 cycles -> resp_valid/rdata stable throughout, req_ready=0, ram_wr_en=0; IDLE the cycle after the handshake.
- SW @0x10000 and size=11 -> resp_err=1, rdata=0, ram_wr_en never high. With DMEM_MISALIGN_CHECK_EN: LW @0x102 -> err=1. Without the macro: LW @0x102 returns word @0x100.
- Assert tb_rst during RD -> resp_valid=0 immediately, req_ready=0 while reset is high; after release a fresh LW completes normally.
